// File: rtl/fault_mem_pkg.sv
// Shared types for the fault-injecting memory model:
// fault encodings, slot config bundle and counter helper.
package fault_mem_pkg;

  typedef enum logic [2:0] {
    FT_NONE = 3'd0,
    FT_SA   = 3'd1,
    FT_TF   = 3'd2,
    FT_CF   = 3'd3,
    FT_NPSF = 3'd4
  } ftype_e;

  typedef struct packed {
    ftype_e typ;
    logic   val;
  } slot_cfg_t;

  // Codes 5..7 collapse to NONE so they never inject anything.
  function automatic ftype_e decode_type(input logic [2:0] t);
    ftype_e r;
    case (t)
      3'd1:    r = FT_SA;
      3'd2:    r = FT_TF;
      3'd3:    r = FT_CF;
      3'd4:    r = FT_NPSF;
      default: r = FT_NONE;
    endcase
    return r;
  endfunction

  function automatic logic cnt_full(
    input logic [31:0] v,
    input logic [31:0] max
  );
    return v >= max;
  endfunction

endpackage

// File: rtl/fault_slot.sv
// One fault slot: config registers plus the per-access
// victim hit, bit mask, forced value and coupling fire.
module fault_slot
  import fault_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int BITW       = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [2:0]            type_i,
  input  logic [ADDR_WIDTH-1:0] vaddr_i,
  input  logic [BITW-1:0]       vbit_i,
  input  logic [ADDR_WIDTH-1:0] aaddr_i,
  input  logic [BITW-1:0]       abit_i,
  input  logic                  val_i,
  input  logic                  acc_i,
  input  logic                  wr_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [DATA_WIDTH-1:0] old_i,
  input  logic [DATA_WIDTH-1:0] aggr_word_i,
  output logic [ADDR_WIDTH-1:0] vic_addr_o,
  output logic [BITW-1:0]       vic_bit_o,
  output logic [ADDR_WIDTH-1:0] aggr_addr_o,
  output logic                  hit_o,
  output logic [DATA_WIDTH-1:0] mask_o,
  output logic                  frc_o,
  output logic                  cf_o,
  output logic                  cf_val_o
);

  slot_cfg_t             cfg_q, cfg_d;
  logic [ADDR_WIDTH-1:0] vaddr_q, aaddr_q;
  logic [BITW-1:0]       vbit_q, abit_q;

  assign cfg_d = '{typ: decode_type(type_i), val: val_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cfg_q   <= '{typ: FT_NONE, val: 1'b0};
      vaddr_q <= '0;
      aaddr_q <= '0;
      vbit_q  <= '0;
      abit_q  <= '0;
    end else if (we_i) begin
      cfg_q   <= cfg_d;
      vaddr_q <= vaddr_i;
      aaddr_q <= aaddr_i;
      vbit_q  <= vbit_i;
      abit_q  <= abit_i;
    end
  end

  logic old_b, new_b, agg_b, vmatch;

  assign old_b  = old_i[vbit_q];
  assign new_b  = wdata_i[vbit_q];
  assign agg_b  = aggr_word_i[abit_q];
  assign vmatch = acc_i && (addr_i == vaddr_q);

  always_comb begin
    hit_o = 1'b0;
    frc_o = 1'b0;
    cf_o  = 1'b0;
    unique case (cfg_q.typ)
      FT_SA: begin
        hit_o = vmatch;
        frc_o = cfg_q.val;
      end
      FT_TF: begin
        hit_o = vmatch && wr_i &&
                (old_b == !cfg_q.val) &&
                (new_b == cfg_q.val);
        frc_o = old_b;
      end
      FT_NPSF: begin
        hit_o = vmatch && wr_i &&
                (agg_b == cfg_q.val);
        frc_o = old_b;
      end
      FT_CF: begin
        cf_o = acc_i && wr_i &&
               (addr_i == aaddr_q) &&
               (old_i[abit_q] != wdata_i[abit_q]);
      end
      default: ;
    endcase
  end

  always_comb begin
    mask_o = '0;
    mask_o[vbit_q] = 1'b1;
  end

  assign vic_addr_o  = vaddr_q;
  assign vic_bit_o   = vbit_q;
  assign aggr_addr_o = aaddr_q;
  assign cf_val_o    = cfg_q.val;

endmodule

// File: rtl/fault_mem_cfg.sv
// Single-port memory model with NUM_FAULTS programmable
// fault slots, pipelined reads and activation reporting.
module fault_mem_cfg
  import fault_mem_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 6,
  parameter int CAPACITY     = 64,
  parameter int NUM_FAULTS   = 2,
  parameter int READ_LATENCY = 1,
  parameter int CNT_WIDTH    = 8,
  localparam int IDXW = (NUM_FAULTS > 1) ?
                        $clog2(NUM_FAULTS) : 1,
  localparam int BITW = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  write_read,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  input  logic                  cfg_we,
  input  logic [IDXW-1:0]       cfg_idx,
  input  logic [2:0]            cfg_type,
  input  logic [ADDR_WIDTH-1:0] cfg_addr,
  input  logic [BITW-1:0]       cfg_bit,
  input  logic [ADDR_WIDTH-1:0] cfg_aggr_addr,
  input  logic [BITW-1:0]       cfg_aggr_bit,
  input  logic                  cfg_val,
  output logic                  fault_hit,
  output logic [CNT_WIDTH-1:0]  fault_cnt
);

  localparam int MIW = (CAPACITY > 1) ?
                       $clog2(CAPACITY) : 1;
  localparam logic [ADDR_WIDTH:0] CAP =
    (ADDR_WIDTH+1)'(CAPACITY);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  function automatic logic in_rng(
    input logic [ADDR_WIDTH-1:0] a
  );
    return {1'b0, a} < CAP;
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [CAPACITY];

  logic                  acc, wr_acc, rd_acc, a_ok;
  logic [DATA_WIDTH-1:0] old_w;

  assign a_ok   = in_rng(address);
  assign acc    = en && !rst;
  assign wr_acc = acc && write_read && a_ok;
  assign rd_acc = acc && !write_read;
  assign old_w  = a_ok ? mem_q[address[MIW-1:0]] : '0;

  logic [NUM_FAULTS-1:0] hit, frc, cf, cf_val;
  logic [DATA_WIDTH-1:0] mask      [NUM_FAULTS];
  logic [DATA_WIDTH-1:0] aggr_word [NUM_FAULTS];
  logic [DATA_WIDTH-1:0] vic_word  [NUM_FAULTS];
  logic [ADDR_WIDTH-1:0] vic_addr  [NUM_FAULTS];
  logic [ADDR_WIDTH-1:0] aggr_addr [NUM_FAULTS];
  logic [BITW-1:0]       vic_bit   [NUM_FAULTS];

  for (genvar g = 0; g < NUM_FAULTS; g++) begin : g_slot
    fault_slot #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .BITW       (BITW)
    ) u_slot (
      .clk_i       (clk),
      .rst_i       (rst),
      .we_i        (cfg_we && (cfg_idx == IDXW'(g))),
      .type_i      (cfg_type),
      .vaddr_i     (cfg_addr),
      .vbit_i      (cfg_bit),
      .aaddr_i     (cfg_aggr_addr),
      .abit_i      (cfg_aggr_bit),
      .val_i       (cfg_val),
      .acc_i       (acc && a_ok),
      .wr_i        (write_read),
      .addr_i      (address),
      .wdata_i     (wdata),
      .old_i       (old_w),
      .aggr_word_i (aggr_word[g]),
      .vic_addr_o  (vic_addr[g]),
      .vic_bit_o   (vic_bit[g]),
      .aggr_addr_o (aggr_addr[g]),
      .hit_o       (hit[g]),
      .mask_o      (mask[g]),
      .frc_o       (frc[g]),
      .cf_o        (cf[g]),
      .cf_val_o    (cf_val[g])
    );

    assign aggr_word[g] = in_rng(aggr_addr[g]) ?
      mem_q[aggr_addr[g][MIW-1:0]] : '0;
    assign vic_word[g] = in_rng(vic_addr[g]) ?
      mem_q[vic_addr[g][MIW-1:0]] : '0;
  end

  logic [DATA_WIDTH-1:0] word_d, rd_ret;
  logic [NUM_FAULTS-1:0] cf_oth;
  logic                  act_cf, hit_d;

  // Slots merge in index order so a higher slot wins;
  // couplings onto the accessed word land last.
  always_comb begin
    word_d = write_read ? wdata : old_w;
    cf_oth = '0;
    act_cf = 1'b0;
    for (int i = 0; i < NUM_FAULTS; i++) begin
      if (hit[i])
        word_d = (word_d & ~mask[i]) |
                 (frc[i] ? mask[i] : '0);
    end
    for (int i = 0; i < NUM_FAULTS; i++) begin
      if (cf[i] && in_rng(vic_addr[i])) begin
        if (vic_addr[i] == address) begin
          word_d[vic_bit[i]] = cf_val[i];
        end else begin
          cf_oth[i] = 1'b1;
          if (vic_word[i][vic_bit[i]] != cf_val[i])
            act_cf = 1'b1;
        end
      end
    end
    rd_ret = a_ok ? word_d : '0;
    if (wr_acc)
      hit_d = (word_d != wdata) || act_cf;
    else
      hit_d = rd_acc && a_ok && (word_d != old_w);
  end

  always_ff @(posedge clk) begin
    if (wr_acc)
      mem_q[address[MIW-1:0]] <= word_d;
    for (int i = 0; i < NUM_FAULTS; i++) begin
      if (cf_oth[i])
        mem_q[vic_addr[i][MIW-1:0]][vic_bit[i]]
          <= cf_val[i];
    end
  end

  logic [READ_LATENCY-1:0] vld_q;
  logic [DATA_WIDTH-1:0]   dat_q [READ_LATENCY];
  logic                    hit_q;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;

  assign cnt_d =
    (hit_d && !cnt_full(32'(cnt_q), 32'(CNT_MAX))) ?
    cnt_q + CNT_WIDTH'(1) : cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int k = 0; k < READ_LATENCY; k++)
        dat_q[k] <= '0;
      hit_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      vld_q[0] <= rd_acc;
      if (rd_acc)
        dat_q[0] <= rd_ret;
      for (int k = 1; k < READ_LATENCY; k++) begin
        vld_q[k] <= vld_q[k-1];
        dat_q[k] <= dat_q[k-1];
      end
      hit_q <= hit_d;
      cnt_q <= cnt_d;
    end
  end

  assign rdata     = dat_q[READ_LATENCY-1];
  assign rvalid    = vld_q[READ_LATENCY-1];
  assign fault_hit = hit_q;
  assign fault_cnt = cnt_q;

endmodule
